uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 8'd200, idle cycles a packet owner may stall before its lock is revoked (range 1..255).
REQ-002 SHALL have port: clock115200hz  input  1  bit-rate clock; all logic on its rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester byte-valid; bit i belongs to requester i.
REQ-005 SHALL have port: req_data  input  32  packed bytes; requester i owns bits [8i+7:8i].
REQ-006 SHALL have port: req_last  input  4  byte presented by requester i ends its packet.
REQ-007 SHALL have port: ack  output  4  one-cycle pulse; requester i's byte captured.
REQ-008 SHALL have port: owner  output  2  index of current or last granted requester.
REQ-009 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port: tx_data  output  8  byte to the shared UART transmitter.
REQ-011 SHALL have port: tx_send  output  1  one-cycle start strobe to the transmitter.
REQ-012 SHALL have port: tx_ready  input  1  transmitter idle; registered, and stays high one cycle after an accepted strobe.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, WAIT_BUSY, WAIT_DONE, and HOLD.
REQ-014 In IDLE with any req bit high, SHALL grant round-robin, starting at (owner+1) mod 4, capture req_data of the winner into tx_data, pulse ack for the winner, latch its req_last, and go to SEND.
REQ-015 In SEND, SHALL wait for tx_ready=1, then assert tx_send for exactly one cycle and go to WAIT_BUSY.
REQ-016 In WAIT_BUSY, SHALL ignore tx_ready until it reads 0, then go to WAIT_DONE.
REQ-017 In WAIT_DONE, on tx_ready=1, SHALL go to IDLE if the latched last=1; otherwise it SHALL go to HOLD.
REQ-018 tx_data SHALL stay constant from capture until WAIT_DONE exits; the transmitter samples it serially over 10 cycles.
REQ-019 In HOLD, only the owner SHALL be served; owner req=1 SHALL capture its byte, pulse ack, and go to SEND, while other requesters stay blocked.
REQ-020 ack SHALL be at most one-hot, and SHALL never pulse in a cycle where the FSM is outside IDLE or HOLD.
REQ-021 Minimum byte-to-byte spacing SHALL be 12 cycles: capture, strobe, 9 busy cycles, done.
REQ-022 A requester deasserting req before ack SHALL lose that arbitration; it SHALL NOT be an error.
REQ-023 req, req_data, and req_last SHALL be sampled only in the ack cycle; changes at any other time SHALL be ignored.
REQ-024 owner SHALL update only on a grant from IDLE.

Reset
REQ-025 On resetn=0 (asynchronous), SHALL force: state=IDLE, ack=0, owner=3 (so requester 0 wins first), tx_data=8'h00, tx_send=0, busy=0, latched last=1, timeout counter=0.
REQ-026 Reset mid-packet or mid-byte SHALL abandon the transfer with no ack and no tx_send afterwards; the first post-reset grant SHALL follow REQ-014.

Configuration
REQ-027 Macro UART_TX_SCHEDULER_TIMEOUT_EN SHALL control the lock-timeout feature.
REQ-028 When the macro is defined, an 8-bit counter SHALL increment each HOLD cycle with owner req=0, clear on leaving HOLD, and on reaching TIMEOUT_CYCLES force IDLE, releasing the lock; no tx_send SHALL be issued for that event.
REQ-029 When the macro is undefined, HOLD SHALL persist indefinitely until owner req=1, and no counter SHALL be synthesized.

Verification
REQ-030 The bench SHALL apply req=4'b0001, data 8'h41, last=1 -> ack[0] pulses once, tx_data=8'h41, one tx_send, then busy low 12 cycles after ack.
REQ-031 The bench SHALL apply req=4'b1111 held, all last=1, from reset -> grants in order 0,1,2,3,0, with exactly one ack per byte.
REQ-032 The bench SHALL run requester 2 sending 3 bytes 8'h10/8'h11/8'h12 (last on the third) while req=4'b1011 -> all three bytes are contiguous on tx_data, and owner=2 throughout.
REQ-033 The bench SHALL hold tx_ready=1 for one cycle after tx_send -> the FSM stays in WAIT_BUSY, and no second tx_send occurs.
REQ-034 With UART_TX_SCHEDULER_TIMEOUT_EN and TIMEOUT_CYCLES=5, the bench SHALL have the owner stall after a non-last byte while req[1]=1 -> after 5 HOLD cycles requester 1 is acked.
REQ-035 The bench SHALL assert resetn=0 during WAIT_BUSY of a packet's second byte -> all outputs take their reset values immediately, with no further ack or tx_send.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Arbitrates four byte-stream requesters onto a single shared
//             UART transmitter. Requests are granted round-robin. A packet
//             owner keeps the transmitter until it presents a byte marked
//             last, so the bytes of one packet are never interleaved with
//             bytes from other requesters.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES  idle HOLD cycles before an owner's lock is revoked
//                    (1..255). Only used when UART_TX_SCHEDULER_TIMEOUT_EN
//                    is defined.
//  Optional feature macro
//    UART_TX_SCHEDULER_TIMEOUT_EN  enables the packet-lock timeout counter.
//  Ports
//    clock115200hz  in   1   bit-rate clock, rising edge
//    resetn         in   1   asynchronous active-low reset
//    req            in   4   per-requester byte valid
//    req_data       in  32   requester i byte in [8i+7:8i]
//    req_last       in   4   presented byte ends the requester's packet
//    ack            out  4   one-cycle capture pulse, at most one-hot
//    owner          out  2   current / most recent IDLE grantee
//    busy           out  1   scheduler not in IDLE
//    tx_data        out  8   byte for the transmitter, stable while in use
//    tx_send        out  1   one-cycle transmitter start strobe
//    tx_ready       in   1   transmitter idle
// ============================================================================
module uart_tx_scheduler #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic        clock115200hz,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        last_q, last_d;

    logic [3:0]  grant;
    logic        send_c;

    // Round-robin search results.
    logic        rr_found;
    logic [1:0]  rr_idx;
    logic [1:0]  rr_cand;

    // A zero timeout would revoke every lock on the first HOLD cycle.
    generate
        if (TIMEOUT_CYCLES == 8'd0) begin : g_timeout_range_check
            $error("uart_tx_scheduler: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

`ifdef UART_TX_SCHEDULER_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: scan owner+1, owner+2, owner+3, owner. The 2-bit
    // add wraps naturally, so the previous owner is checked last.
    // ------------------------------------------------------------------
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = owner_q;
        rr_cand  = owner_q;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = owner_q + 2'(k);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        grant     = 4'b0000;
        send_c    = 1'b0;
`ifdef UART_TX_SCHEDULER_TIMEOUT_EN
        // The counter only survives while the scheduler remains in HOLD
        // with the owner idle; every other path clears it.
        tmo_d     = 8'd0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant[rr_idx] = 1'b1;
                    owner_d       = rr_idx;
                    tx_data_d     = req_data[{rr_idx, 3'b000} +: 8];
                    last_d        = req_last[rr_idx];
                    state_d       = ST_SEND;
                end
            end

            ST_SEND: begin
                if (tx_ready) begin
                    send_c  = 1'b1;
                    state_d = ST_WAIT_BUSY;
                end
            end

            // tx_ready is still high for one cycle after the strobe; only
            // a low reading proves the transmitter has taken the byte.
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = last_q ? ST_IDLE : ST_HOLD;
                end
            end

            // Packet lock: only the owner can be served here.
            ST_HOLD: begin
                if (req[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    tx_data_d      = req_data[{owner_q, 3'b000} +: 8];
                    last_d         = req_last[owner_q];
                    state_d        = ST_SEND;
                end
`ifdef UART_TX_SCHEDULER_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TIMEOUT_CYCLES) begin
                        // Abandon the lock silently; no strobe is issued.
                        tmo_d   = 8'd0;
                        state_d = ST_IDLE;
                    end
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock115200hz or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd3;          // requester 0 wins the first grant
            tx_data_q <= 8'h00;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

`ifdef UART_TX_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge clock115200hz or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs. ack is combinational so that it pulses in the capture
    // cycle itself, while the FSM is still in IDLE or HOLD. It is gated
    // by resetn because reset leaves the FSM in IDLE, where a pending
    // request would otherwise show through.
    // ------------------------------------------------------------------
    assign ack     = grant & {4{resetn}};
    assign owner   = owner_q;
    assign busy    = (state_q != ST_IDLE);
    assign tx_data = tx_data_q;
    assign tx_send = send_c;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_scheduler
//  Purpose  : Self-checking bench for uart_tx_scheduler. Requesters are
//             byte queues; a small transmitter model drives tx_ready. A
//             transaction-level model tracks the expected grant order,
//             packet lock, owner and in-flight byte, and is compared with
//             the DUT on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;

    uart_tx_scheduler #(.TIMEOUT_CYCLES(8'd5)) dut (
        .clock115200hz (clk),
        .resetn        (resetn),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .ack           (ack),
        .owner         (owner),
        .busy          (busy),
        .tx_data       (tx_data),
        .tx_send       (tx_send),
        .tx_ready      (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester queues (data[7:0], last[8]) --------------
    logic [8:0] rbuf [4][8];
    int         rhead [4];
    int         rtail [4];

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rbuf[i][rtail[i] % 8] = {l, d};
        rtail[i]++;
    endtask

    task automatic clear_q(input int i);
        rhead[i] = rtail[i];
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < 4; i++) if (rtail[i] != rhead[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [3:0] a;
        for (int i = 0; i < 4; i++) begin rhead[i] = 0; rtail[i] = 0; end
        req = 4'b0; req_data = 32'h0; req_last = 4'b0;
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (a[i] && rtail[i] != rhead[i]) rhead[i]++;
                if (rtail[i] != rhead[i]) begin
                    req[i]            = 1'b1;
                    req_data[i*8 +: 8] = rbuf[i][rhead[i] % 8][7:0];
                    req_last[i]       = rbuf[i][rhead[i] % 8][8];
                end else begin
                    // Junk on an idle lane must never reach the transmitter.
                    req[i]            = 1'b0;
                    req_data[i*8 +: 8] = 8'($urandom);
                    req_last[i]       = 1'($urandom);
                end
            end
        end
    end

    // ---------------- transmitter model ----------------------------------
    // After an accepted strobe: ready stays high 1 cycle, low 8 cycles,
    // then high again; tx_done marks the cycle ready returns.
    int tx_cnt  = 0;
    bit tx_done = 1'b0;
    initial begin
        bit s;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            s = tx_send && tx_ready && resetn;
            @(posedge clk);
            #1;
            if (!resetn) begin
                tx_cnt = 0; tx_done = 1'b0; tx_ready = 1'b1;
            end else begin
                tx_done = 1'b0;
                if (s) tx_cnt = 9;
                else if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_done = 1'b1;
                end
                tx_ready = !(tx_cnt >= 1 && tx_cnt <= 8);
            end
        end
    end

    // ---------------- model and compare process ---------------------------
    logic [1:0] m_owner = 2'd3;
    bit         locked  = 1'b0;
    bit         pending = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         chk_busy = 1'b1;
    bit         tmo_ok   = 1'b0;
    int         glog [64];
    int         gn = 0;
    logic [7:0] slog [64];
    int         sn = 0;

    initial begin
        int idx;
        int expw;
        bit inflight;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_owner = 2'd3; locked = 1'b0; pending = 1'b0; m_data = 8'h00;
                chk("rst_ack", ack, 0);
                chk("rst_send", tx_send, 0);
                chk("rst_busy", busy, 0);
                chk("rst_owner", owner, 3);
                chk("rst_txdata", tx_data, 0);
                continue;
            end
            inflight = pending || tx_cnt > 0 || tx_done;
            chk("owner", owner, m_owner);
            if (chk_busy) chk("busy", busy, inflight || locked);
            if (inflight) chk("tx_data_stable", tx_data, m_data);
            if (tx_send) begin
                chk("send_legal", pending && tx_ready, 1);
                chk("send_data", tx_data, m_data);
                if (sn < 64) slog[sn] = tx_data;
                sn++;
                pending = 1'b0;
            end else if (pending && tx_ready) begin
                chk("send_missing", tx_send, 1);
            end
            if (ack != 4'b0) begin
                chk("ack_onehot", $onehot(ack), 1);
                chk("ack_while_inflight", inflight, 0);
                idx = 0;
                for (int i = 3; i >= 0; i--) if (ack[i]) idx = i;
                if (locked && tmo_ok && idx != int'(m_owner)) locked = 1'b0;
                if (locked) expw = m_owner;
                else begin
                    expw = -1;
                    for (int k = 1; k <= 4; k++)
                        if (expw < 0 && req[(m_owner + k) % 4]) expw = (m_owner + k) % 4;
                end
                chk("ack_winner", idx, expw);
                chk("ack_req", req[idx], 1);
                m_data = req_data[idx*8 +: 8];
                if (!locked) m_owner = 2'(idx);
                locked  = !req_last[idx];
                pending = 1'b1;
                if (gn < 64) glog[gn] = idx;
                gn++;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic do_reset();
        @(negedge clk); #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int maxc);
        bit ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            if (ack[i]) ok = 1'b1;
        end
        chk("wait_ack_bound", ok, 1);
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            if (queues_empty() && !busy && !pending && tx_cnt == 0 && !tx_done) ok = 1'b1;
        end
        chk("wait_idle_bound", ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- directed tests ---------------------------------------
    initial begin
        int acks0, sends, d, g0, s0;
        int eg [6];
        logic [7:0] eb [6];
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;

        // Single byte from requester 0: capture, strobe, busy for 12 cycles.
        push(0, 8'h41, 1'b1);
        wait_ack(0, 50);
        acks0 = 1; sends = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ack[0]) acks0++;
            if (tx_send) sends++;
            if (k == 1) chk("t1_txdata", tx_data, 8'h41);
            if (k == 2) begin
                chk("t1_wb_ready_high", tx_ready, 1);
                chk("t1_wb_no_send", tx_send, 0);
                chk("t1_wb_busy", busy, 1);
            end
            if (k == 11) chk("t1_busy_at_11", busy, 1);
            if (k == 12) chk("t1_busy_at_12", busy, 0);
        end
        chk("t1_ack_count", acks0, 1);
        chk("t1_send_count", sends, 1);

        // All four requesting from reset: 0,1,2,3,0.
        do_reset();
        gn = 0; sn = 0;
        push(0, 8'hA0, 1'b1); push(0, 8'hA4, 1'b1);
        push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
        wait_idle(300);
        eg = '{0, 1, 2, 3, 0, 0};
        eb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
        chk("t2_grant_count", gn, 5);
        chk("t2_send_count", sn, 5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_grant_order", glog[k], eg[k]);
            chk("t2_byte_order", slog[k], eb[k]);
        end

        // Requester 2 packet of three bytes while 0,1,3 also request.
        push(1, 8'h55, 1'b1);
        wait_idle(100);
        chk("t3_owner_setup", owner, 1);
        gn = 0; sn = 0;
        push(2, 8'h10, 1'b0); push(2, 8'h11, 1'b0); push(2, 8'h12, 1'b1);
        push(0, 8'h20, 1'b1); push(1, 8'h21, 1'b1); push(3, 8'h23, 1'b1);
        wait_idle(400);
        eg = '{2, 2, 2, 3, 0, 1};
        eb = '{8'h10, 8'h11, 8'h12, 8'h23, 8'h20, 8'h21};
        chk("t3_grant_count", gn, 6);
        for (int k = 0; k < 6; k++) begin
            chk("t3_grant_order", glog[k], eg[k]);
            chk("t3_byte_order", slog[k], eb[k]);
        end

        // Requester 3 withdraws before it could be granted.
        gn = 0;
        push(0, 8'h60, 1'b1);
        wait_ack(0, 50);
        repeat (2) @(negedge clk);
        push(3, 8'h99, 1'b1);
        repeat (3) @(negedge clk);
        clear_q(3);
        wait_idle(100);
        chk("t5_grant_count", gn, 1);
        chk("t5_grant", glog[0], 0);

        // Reset during WAIT_BUSY of a packet's second byte.
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        wait_ack(1, 50);
        wait_ack(1, 50);
        @(negedge clk);
        chk("t6_second_strobe", tx_send, 1);
        @(negedge clk);
        #1 resetn = 1'b0;
        for (int i = 0; i < 4; i++) clear_q(i);
        #1;
        chk("t6_async_ack", ack, 0);
        chk("t6_async_send", tx_send, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_owner", owner, 3);
        chk("t6_async_txdata", tx_data, 0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        g0 = gn; s0 = sn;
        repeat (20) @(negedge clk);
        chk("t6_no_ack_after", gn, g0);
        chk("t6_no_send_after", sn, s0);
        push(0, 8'h70, 1'b1); push(2, 8'h72, 1'b1);
        wait_idle(100);
        chk("t6_first_grant", glog[g0], 0);
        chk("t6_second_grant", glog[g0 + 1], 2);

        // Owner stalls after a non-last byte while requester 1 waits.
        do_reset();
        gn = 0;
`ifdef UART_TX_SCHEDULER_TIMEOUT_EN
        chk_busy = 1'b0; tmo_ok = 1'b1;
        push(0, 8'h50, 1'b0); push(1, 8'h51, 1'b1);
        wait_ack(0, 50);
        d = 0; sends = 0;
        for (int c = 1; c <= 40 && d == 0; c++) begin
            @(negedge clk);
            if (tx_send && c >= 2) sends++;
            if (ack[1]) d = c;
        end
        chk("t7_release_delay", d, 17);
        chk("t7_no_strobe_on_release", sends, 0);
        wait_idle(100);
        chk_busy = 1'b1; tmo_ok = 1'b0;
        chk("t7_grant_count", gn, 2);
        chk("t7_grant_after_timeout", glog[1], 1);
`else
        push(0, 8'h50, 1'b0); push(1, 8'h51, 1'b1);
        wait_ack(0, 50);
        d = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack[1]) d++;
        end
        chk("t7_hold_blocks_other", d, 0);
        chk("t7_hold_busy", busy, 1);
        chk("t7_hold_owner", owner, 0);
        push(0, 8'h52, 1'b1);
        wait_idle(100);
        chk("t7_grant_count", gn, 3);
        chk("t7_owner_resumes", glog[1], 0);
        chk("t7_then_other", glog[2], 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
